// File: rtl/alu_pipe_if.sv
// Issue/writeback bus for alu_pipe: valid/ready operation in, valid/ready result out.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Overflow;
  logic             Carry;
  logic             busy;

  // Issue/writeback side
  modport master (
    output in_valid, A, B, ALUControl, out_ready,
    input  in_ready, out_valid, Result, Zero, Overflow, Carry, busy
  );

  // ALU side
  modport slave (
    input  in_valid, A, B, ALUControl, out_ready,
    output in_ready, out_valid, Result, Zero, Overflow, Carry, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered results, one-entry output register and a
// bit-serial shift-add multiplier (one multiplier bit per cycle).
module alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_INC   = 4'b1000;
  localparam logic [3:0] OP_DEC   = 4'b1001;
  localparam logic [3:0] OP_SLT   = 4'b1010;
  localparam logic [3:0] OP_SLTU  = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b1100;
  localparam logic [3:0] OP_MULHU = 4'b1101;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic             hi_sel;

  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic             drain;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_w, sub_w, inc_w, dec_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cy, alu_ov;
  logic [PW-1:0]    addend, prod;
  logic [WIDTH-1:0] mul_res;
  logic             mul_cy;

  // Handshake qualifiers
  assign bus.in_ready = rst_n && (state == S_IDLE) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = bus.out_valid && bus.out_ready;
  assign is_mul       = (bus.ALUControl == OP_MUL) || (bus.ALUControl == OP_MULHU);
  assign mul_done     = (state == S_MUL) && (cnt == SHW'(WIDTH - 1));
  assign bus.busy     = (state == S_MUL);

  // Shared (WIDTH+1)-bit arithmetic; bit WIDTH is carry-out or borrow
  assign sh    = bus.B[SHW-1:0];
  assign add_w = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_w = {1'b0, bus.A} - {1'b0, bus.B};
  assign inc_w = {1'b0, bus.A} + (WIDTH+1)'(1);
  assign dec_w = {1'b0, bus.A} - (WIDTH+1)'(1);

  // Single-cycle result and flags for the operand pair on the bus
  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    alu_ov  = 1'b0;
    case (bus.ALUControl)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_cy  = add_w[WIDTH];
        alu_ov  = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_cy  = sub_w[WIDTH];
        alu_ov  = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sub_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.A & bus.B;
      OP_OR:   alu_res = bus.A | bus.B;
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_SLL:  alu_res = bus.A << sh;
      OP_SRL:  alu_res = bus.A >> sh;
      OP_SRA:  alu_res = WIDTH'($signed(bus.A) >>> sh);
      OP_INC: begin
        alu_res = inc_w[WIDTH-1:0];
        alu_cy  = inc_w[WIDTH];
        alu_ov  = (bus.A == MAX_POS);
      end
      OP_DEC: begin
        alu_res = dec_w[WIDTH-1:0];
        alu_cy  = dec_w[WIDTH];
        alu_ov  = (bus.A == MIN_NEG);
      end
      OP_SLT:  alu_res = WIDTH'($signed(bus.A) < $signed(bus.B));
      OP_SLTU: alu_res = WIDTH'(bus.A < bus.B);
      default: alu_res = '0;
    endcase
  end

  // Final multiply step folds in the last multiplier bit
  assign addend  = mplier[0] ? mcand : '0;
  assign prod    = acc + addend;
  assign mul_res = hi_sel ? prod[PW-1:WIDTH] : prod[WIDTH-1:0];
  assign mul_cy  = !hi_sel && (|prod[PW-1:WIDTH]);

  // Control FSM, multiplier datapath and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      hi_sel       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.Result   <= '0;
      bus.Zero     <= 1'b0;
      bus.Overflow <= 1'b0;
      bus.Carry    <= 1'b0;
    end else begin
      if (drain) bus.out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state  <= S_MUL;
              mcand  <= {{WIDTH{1'b0}}, bus.A};
              mplier <= bus.B;
              acc    <= '0;
              cnt    <= '0;
              hi_sel <= (bus.ALUControl == OP_MULHU);
            end else begin
              bus.out_valid <= 1'b1;
              bus.Result    <= alu_res;
              bus.Zero      <= (alu_res == '0);
              bus.Overflow  <= alu_ov;
              bus.Carry     <= alu_cy;
            end
          end
        end
        S_MUL: begin
          acc    <= prod;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHW'(1);
          if (mul_done) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bus.out_valid <= 1'b1;
            bus.Result    <= mul_res;
            bus.Zero      <= (mul_res == '0);
            bus.Overflow  <= 1'b0;
            bus.Carry     <= mul_cy;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
